// File: rtl/median_window_ctrl.sv
// Sliding 3x4 window sequencer for the median compare network.
// Accepts one 3-pixel column per beat, emits tagged windows that slide by two columns.
`timescale 1ns / 1ps
module median_window_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  col_valid,
    output logic                  col_ready,
    input  logic [DATA_WIDTH-1:0] col_y1,
    input  logic [DATA_WIDTH-1:0] col_y0,
    input  logic [DATA_WIDTH-1:0] col_ym1,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [DATA_WIDTH-1:0] x2_y1,
    output logic [DATA_WIDTH-1:0] x2_y0,
    output logic [DATA_WIDTH-1:0] x2_ym1,
    output logic [DATA_WIDTH-1:0] x1_y1,
    output logic [DATA_WIDTH-1:0] x1_y0,
    output logic [DATA_WIDTH-1:0] x1_ym1,
    output logic [DATA_WIDTH-1:0] x0_y1,
    output logic [DATA_WIDTH-1:0] x0_y0,
    output logic [DATA_WIDTH-1:0] x0_ym1,
    output logic [DATA_WIDTH-1:0] xm1_y1,
    output logic [DATA_WIDTH-1:0] xm1_y0,
    output logic [DATA_WIDTH-1:0] xm1_ym1,
    output logic                  win_sof,
    output logic                  win_eol,
    output logic                  win_eof
);

    localparam int unsigned NW  = (IMG_WIDTH - 2) / 2;
    localparam int unsigned WCW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned LCW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned CW  = 3 * DATA_WIDTH;
    localparam logic [WCW-1:0] WcntLast = WCW'(NW - 1);
    localparam logic [LCW-1:0] LcntLast = LCW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {StFill4, StFill2, StHold} state_e;

    state_e         state_q, state_d;
    logic [1:0]     fcnt_q, fcnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    // Column registers packed as {y1, y0, ym1}; c2 is the oldest column.
    logic [CW-1:0]  c2_q, c1_q, c0_q, cm1_q;
    logic           col_acc;
    logic           last_win;

    assign col_acc  = col_valid & col_ready;
    assign last_win = (wcnt_q == WcntLast);

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        wcnt_d    = wcnt_q;
        lcnt_d    = lcnt_q;
        col_ready = 1'b0;
        win_valid = 1'b0;
        case (state_q)
            StFill4, StFill2: begin
                col_ready = 1'b1;
                if (col_valid) begin
                    if (fcnt_q == ((state_q == StFill4) ? 2'd3 : 2'd1)) begin
                        fcnt_d  = 2'd0;
                        state_d = StHold;
                    end else begin
                        fcnt_d = fcnt_q + 2'd1;
                    end
                end
            end
            StHold: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    state_d = last_win ? StFill4 : StFill2;
                    if (last_win) begin
                        wcnt_d = '0;
                        lcnt_d = (lcnt_q == LcntLast) ? '0 : lcnt_q + 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StFill4;
        endcase
    end

    assign win_sof = win_valid & (wcnt_q == '0) & (lcnt_q == '0);
    assign win_eol = win_valid & last_win;
    assign win_eof = win_eol & (lcnt_q == LcntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill4;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            lcnt_q  <= '0;
            c2_q    <= '0;
            c1_q    <= '0;
            c0_q    <= '0;
            cm1_q   <= '0;
        end else if (clr) begin
            state_q <= StFill4;
            fcnt_q  <= '0;
            wcnt_q  <= '0;
            lcnt_q  <= '0;
            c2_q    <= '0;
            c1_q    <= '0;
            c0_q    <= '0;
            cm1_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            lcnt_q  <= lcnt_d;
            if (col_acc) begin
                c2_q  <= c1_q;
                c1_q  <= c0_q;
                c0_q  <= cm1_q;
                cm1_q <= {col_y1, col_y0, col_ym1};
            end
        end
    end

    assign {x2_y1, x2_y0, x2_ym1}    = c2_q;
    assign {x1_y1, x1_y0, x1_ym1}    = c1_q;
    assign {x0_y1, x0_y0, x0_ym1}    = c0_q;
    assign {xm1_y1, xm1_y0, xm1_ym1} = cm1_q;

endmodule
